// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizes for the sequential divider
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W = $clog2(DIV_WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring iteration on {rem,quo}, producing one quotient bit
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_WIDTH
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dsr_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);
  logic [W:0] sh, trial;
  // the extra top bit keeps the borrow when rem already has its MSB set
  always_comb begin
    sh = {rem_i, quo_i[W-1]};
    trial = sh - {1'b0, dsr_i};
    rem_o = trial[W] ? sh[W-1:0] : trial[W-1:0];
    quo_o = {quo_i[W-2:0], ~trial[W]};
  end
endmodule

// File: rtl/div_seq.sv
// div_seq: multicycle restoring divider, remainder on hi_out, quotient on lo_out.
// Define DIV_SIGNED_EN for two's-complement operands; unsigned otherwise.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dsr_q, rem_d, quo_d;
  logic neg_q_q, neg_r_q, sa, sb;
`ifdef DIV_SIGNED_EN
  assign sa = dividend[WIDTH-1];
  assign sb = divisor[WIDTH-1];
`else
  assign sa = 1'b0;
  assign sb = 1'b0;
`endif
  assign busy = state_q != IDLE;
  div_step #(.W(WIDTH)) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dsr_i(dsr_q),
    .rem_o(rem_d),
    .quo_o(quo_d)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
      done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          if (divisor == '0) begin
            done <= 1'b1;
            div_zero <= 1'b1;
            state_q <= DONE;
          end else begin
            rem_q <= '0;
            quo_q <= sa ? -dividend : dividend;
            dsr_q <= sb ? -divisor : divisor;
            neg_q_q <= sa ^ sb;
            neg_r_q <= sa;
            cnt_q <= CNT_W'(WIDTH - 1);
            state_q <= RUN;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          hi_out <= neg_r_q ? -rem_q : rem_q;
          lo_out <= neg_q_q ? -quo_q : quo_q;
          done <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          done <= 1'b0;
          div_zero <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vectors against hand-computed quotients and remainders
module tb_div_seq;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] dividend = '0, divisor = '0, hi_out, lo_out;
  logic busy, done, div_zero;
  int total = 0, bad = 0;

  div_seq dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
    dividend = ~a;
    divisor = ~b;
  endtask

  task automatic wait_done(output int n, output int bcnt);
    n = 0;
    bcnt = 1;
    while (!done && n < 40) begin
      @(posedge clk);
      #1 n++;
      bcnt += int'(busy);
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r);
    int n, bcnt;
    go(a, b);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(n, bcnt);
    chk({tag, "_lat"}, n, 33);
    chk({tag, "_lo"}, lo_out, q);
    chk({tag, "_hi"}, hi_out, r);
    chk({tag, "_dz"}, 32'(div_zero), 32'd0);
    @(posedge clk);
    #1 chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_busy_cnt"}, bcnt, 34);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n, bcnt, seen;
    #12;
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    @(negedge clk) reset = 1'b0;

    run_div("u100_7", 32'd100, 32'd7, 32'd14, 32'd2);
`ifdef DIV_SIGNED_EN
    run_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("s_7_m2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    run_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    run_div("s_m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE);
`else
    run_div("u_max_msb", 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h7FFFFFFF);
    run_div("u_msb_max", 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run_div("u_5_9", 32'd5, 32'd9, 32'd0, 32'd5);
    run_div("u_div1", 32'hDEADBEEF, 32'd1, 32'hDEADBEEF, 32'd0);
`endif

    run_div("u_prime", 32'd1000, 32'd3, 32'd333, 32'd1);
    go(32'd55, 32'd0);
    chk("dz_done", 32'(done), 32'd1);
    chk("dz_flag", 32'(div_zero), 32'd1);
    chk("dz_lo_kept", lo_out, 32'd333);
    chk("dz_hi_kept", hi_out, 32'd1);
    @(posedge clk);
    #1 chk("dz_clr", {30'd0, done, div_zero}, 32'd0);
    chk("dz_idle", 32'(busy), 32'd0);

    go(32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    dividend = 32'd9;
    divisor = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, bcnt);
    chk("mid_done", 32'(done), 32'd1);
    chk("mid_lo", lo_out, 32'd142);
    chk("mid_hi", hi_out, 32'd6);
    repeat (3) @(posedge clk);
    #1 chk("mid_no_restart", 32'(busy), 32'd0);

    go(32'd100, 32'd7);
    repeat (19) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("arst_hi", hi_out, 32'd0);
    chk("arst_lo", lo_out, 32'd0);
    chk("arst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    @(negedge clk) reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 seen += int'(done | busy);
    end
    chk("arst_quiet", seen, 0);
    run_div("post_rst", 32'd100, 32'd7, 32'd14, 32'd2);

    @(negedge clk);
    start = 1'b1;
    dividend = 32'd20;
    divisor = 32'd6;
    @(posedge clk);
    #1 wait_done(n, bcnt);
    chk("hold_lat", n, 33);
    chk("hold_lo", lo_out, 32'd3);
    chk("hold_hi", hi_out, 32'd2);
    @(posedge clk);
    #1 chk("hold_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1 chk("hold_restart", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(n, bcnt);
    chk("hold2_lat", n, 33);
    chk("hold2_lo", lo_out, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
